sb_i2c_cmd_seq: RTL and testbench

- System-bus master that sits directly upstream of the SB_I2C hard IP and drives its SBRWI/SBSTBI/SBADRI/SBDATI pins.
- Accepts register-level commands from fabric logic over a valid/ready interface. Supported ops: write, read, poll-until-match.
- Runs each command as an SB strobe/ack handshake and returns read data plus a status code on a valid/ready response channel.

---
 rtl/sb_i2c_pkg.sv | 44 ++++
 rtl/sb_i2c_cmd_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_sb_i2c_cmd_seq.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_i2c_pkg.sv
// Shared types for the SB_I2C command sequencer: ops, status codes, FSM states
// and the SB_I2C hard-IP register offsets (low address nibble).
package sb_i2c_pkg;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'd0,
        OP_READ     = 2'd1,
        OP_POLL     = 2'd2,
        OP_WAIT_IRQ = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK             = 2'd0,
        ST_ACK_TMO        = 2'd1,
        ST_POLL_EXHAUSTED = 2'd2,
        ST_BAD_OP         = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STROBE = 3'd1,
        S_GAP    = 3'd2,
        S_RESP   = 3'd3,
        S_WAIT   = 3'd4
    } state_e;

    localparam logic [3:0] I2CSADDR = 4'h3;
    localparam logic [3:0] I2CINTSR = 4'h6;
    localparam logic [3:0] I2CINTCR = 4'h7;
    localparam logic [3:0] I2CCR1   = 4'h8;
    localparam logic [3:0] I2CCMDR  = 4'h9;
    localparam logic [3:0] I2CBRLSB = 4'hA;
    localparam logic [3:0] I2CBRMSB = 4'hB;
    localparam logic [3:0] I2CSR    = 4'hC;
    localparam logic [3:0] I2CTXDR  = 4'hD;
    localparam logic [3:0] I2CRXDR  = 4'hE;
    localparam logic [3:0] I2CGCDR  = 4'hF;

    function automatic logic poll_hit(input logic [7:0] data, input logic [7:0] mask,
                                      input logic [7:0] match);
        return ((data & mask) == (match & mask));
    endfunction

endpackage

// File: rtl/sb_i2c_cmd_seq.sv
// System-bus master for the SB_I2C hard IP: runs WRITE/READ/POLL commands as
// strobe/ack cycles. Optional WAIT_IRQ op enabled by SB_I2C_CMD_SEQ_IRQ_WAIT_EN.
//
// Handshakes: cmd is taken on a rising edge where cmd_valid && cmd_ready; rsp is
// retired on a rising edge where rsp_valid && rsp_ready. A raised valid holds its
// payload stable until that edge; ready never depends combinationally on valid.
module sb_i2c_cmd_seq
    import sb_i2c_pkg::*;
#(
    parameter logic [3:0] BUS_ADDR74  = 4'b0011,
    parameter int         ACK_TIMEOUT = 64,
    parameter int         POLL_MAX    = 255,
    parameter int         POLL_GAP    = 4
) (
    input  logic       sbclki,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    input  logic [7:0] cmd_mask,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_status,
    output logic       sbrwi,
    output logic       sbstbi,
    output logic [7:0] sbadri,
    output logic [7:0] sbdati,
    input  logic [7:0] sbdato,
    input  logic       sbacko,
    input  logic       i2cirq,
    output logic       busy,
    output state_e     dbg_state
);

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    status_e    status_q, status_d;
    logic [7:0] wdata_q, wdata_d, mask_q, mask_d;
    logic [7:0] adr_q, adr_d, dati_q, dati_d, rdata_q, rdata_d;
    logic       stb_q, stb_d, rwi_q, rwi_d, acked_q, acked_d, rdy_en_q;
    logic [7:0] tmo_q, tmo_d, poll_q, poll_d;
    logic [3:0] gap_q, gap_d;

`ifdef SB_I2C_CMD_SEQ_IRQ_WAIT_EN
    logic [15:0] wait_q, wait_d;
    logic        irq_meta_q, irq_sync_q;

    always_ff @(posedge sbclki or negedge resetn) begin
        if (!resetn) begin
            irq_meta_q <= 1'b0;
            irq_sync_q <= 1'b0;
        end else begin
            irq_meta_q <= i2cirq;
            irq_sync_q <= irq_meta_q;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = i2cirq;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        status_d = status_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        adr_d    = adr_q;
        dati_d   = dati_q;
        rdata_d  = rdata_q;
        stb_d    = stb_q;
        rwi_d    = rwi_q;
        acked_d  = acked_q;
        tmo_d    = tmo_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
`ifdef SB_I2C_CMD_SEQ_IRQ_WAIT_EN
        wait_d   = wait_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && rdy_en_q) begin
                    op_d    = op_e'(cmd_op);
                    wdata_d = cmd_wdata;
                    mask_d  = cmd_mask;
                    adr_d   = {BUS_ADDR74, cmd_reg};
                    rdata_d = 8'h00;
                    tmo_d   = 8'd0;
                    poll_d  = 8'd0;
                    acked_d = 1'b0;
                    if (cmd_op == OP_WAIT_IRQ) begin
`ifdef SB_I2C_CMD_SEQ_IRQ_WAIT_EN
                        wait_d  = 16'd0;
                        state_d = S_WAIT;
`else
                        status_d = ST_BAD_OP;
                        state_d  = S_RESP;
`endif
                    end else begin
                        state_d = S_STROBE;
                        stb_d   = 1'b1;
                        rwi_d   = (cmd_op == OP_WRITE);
                        dati_d  = (cmd_op == OP_WRITE) ? cmd_wdata : 8'h00;
                    end
                end
            end
            S_STROBE: begin
                // After the ack edge we spend one cycle with the strobe low to
                // judge the captured byte; sbacko is not looked at in that cycle.
                if (acked_q) begin
                    if (op_q != OP_POLL || poll_hit(rdata_q, mask_q, wdata_q)) begin
                        status_d = ST_OK;
                        state_d  = S_RESP;
                    end else if (poll_q == 8'(POLL_MAX - 1)) begin
                        status_d = ST_POLL_EXHAUSTED;
                        state_d  = S_RESP;
                    end else begin
                        poll_d  = poll_q + 8'd1;
                        acked_d = 1'b0;
                        tmo_d   = 8'd0;
                        gap_d   = 4'd0;
                        if (POLL_GAP == 1) begin
                            stb_d = 1'b1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end else if (sbacko) begin
                    stb_d   = 1'b0;
                    acked_d = 1'b1;
                    if (op_q != OP_WRITE) begin
                        rdata_d = sbdato;
                    end
                end else if (tmo_q == 8'(ACK_TIMEOUT - 1)) begin
                    stb_d    = 1'b0;
                    rdata_d  = 8'h00;
                    status_d = ST_ACK_TMO;
                    state_d  = S_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_GAP: begin
                // The judge cycle already counts as the first idle cycle.
                if (gap_q == 4'(POLL_GAP - 2)) begin
                    stb_d   = 1'b1;
                    tmo_d   = 8'd0;
                    state_d = S_STROBE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef SB_I2C_CMD_SEQ_IRQ_WAIT_EN
            S_WAIT: begin
                if (irq_sync_q) begin
                    rdata_d  = 8'h00;
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (wait_q == 16'(ACK_TIMEOUT * POLL_MAX - 1)) begin
                    rdata_d  = 8'h00;
                    status_d = ST_ACK_TMO;
                    state_d  = S_RESP;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
`endif
            default: begin
                stb_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sbclki or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= OP_WRITE;
            status_q <= ST_OK;
            wdata_q  <= 8'h00;
            mask_q   <= 8'h00;
            adr_q    <= 8'h00;
            dati_q   <= 8'h00;
            rdata_q  <= 8'h00;
            stb_q    <= 1'b0;
            rwi_q    <= 1'b0;
            acked_q  <= 1'b0;
            tmo_q    <= 8'd0;
            poll_q   <= 8'd0;
            gap_q    <= 4'd0;
            rdy_en_q <= 1'b0;
`ifdef SB_I2C_CMD_SEQ_IRQ_WAIT_EN
            wait_q   <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            status_q <= status_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            adr_q    <= adr_d;
            dati_q   <= dati_d;
            rdata_q  <= rdata_d;
            stb_q    <= stb_d;
            rwi_q    <= rwi_d;
            acked_q  <= acked_d;
            tmo_q    <= tmo_d;
            poll_q   <= poll_d;
            gap_q    <= gap_d;
            rdy_en_q <= 1'b1;
`ifdef SB_I2C_CMD_SEQ_IRQ_WAIT_EN
            wait_q   <= wait_d;
`endif
        end
    end

    assign cmd_ready  = rdy_en_q && (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;
    assign sbstbi     = stb_q;
    assign sbrwi      = rwi_q;
    assign sbadri     = adr_q;
    assign sbdati     = dati_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sb_i2c_cmd_seq.sv
// Directed bench for sb_i2c_cmd_seq: bus responder, per-command response model,
// every-cycle compare process and literal pins. Honours SB_I2C_CMD_SEQ_IRQ_WAIT_EN.
`timescale 1ns/1ps
module tb_sb_i2c_cmd_seq;
    import sb_i2c_pkg::*;

    localparam int         ACK_TIMEOUT = 64;
    localparam int         POLL_MAX    = 3;
    localparam int         POLL_GAP    = 4;
    localparam logic [3:0] BUS_ADDR74  = 4'b0011;

    logic       sbclki = 1'b0, resetn = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
    logic [1:0] cmd_op = 2'd0, rsp_status;
    logic [3:0] cmd_reg = 4'd0;
    logic [7:0] cmd_wdata = 8'd0, cmd_mask = 8'd0, rsp_rdata;
    logic       sbrwi, sbstbi, sbacko = 1'b0, i2cirq = 1'b0, busy;
    logic [7:0] sbadri, sbdati, sbdato = 8'd0;
    state_e     dbg_state;

    sb_i2c_cmd_seq #(.BUS_ADDR74(BUS_ADDR74), .ACK_TIMEOUT(ACK_TIMEOUT),
                     .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)) dut (
        .sbclki(sbclki), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .sbrwi(sbrwi), .sbstbi(sbstbi), .sbadri(sbadri),
        .sbdati(sbdati), .sbdato(sbdato), .sbacko(sbacko), .i2cirq(i2cirq),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 sbclki = ~sbclki;
    int cyc = 0;
    always @(posedge sbclki) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0, errors = 0;
    logic [9:0] exp_q[$];
    int         len_q[$];
    logic [7:0] exp_adr = 8'h00, exp_dati = 8'h00;
    logic       exp_rwi = 1'b0;
    logic [7:0] rd_vals[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- bus responder ----------------
    int         ack_dly = 1, stb_cnt = 0, ack_edge = -1;
    logic [7:0] rd_q[$];
    logic       stray_en = 1'b0;

    always @(posedge sbclki) begin
        #1;
        if (sbstbi === 1'b1 && resetn) begin
            stb_cnt++;
            if (ack_dly != 0 && stb_cnt == ack_dly) begin
                sbacko   = 1'b1;
                sbdato   = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                ack_edge = cyc + 1;
            end else begin
                sbacko = 1'b0;
                sbdato = 8'($urandom_range(0, 255));
            end
        end else begin
            stb_cnt = 0;
            sbacko  = stray_en;
            sbdato  = 8'($urandom_range(0, 255));
        end
    end

    // ---------------- compare process ----------------
    logic       stb_prev = 1'b0, rsp_prev = 1'b0;
    int         stb_len = 0, gap_len = 0, stb_idx = 0, stb_first = -1, rsp_first = -1;
    logic [9:0] rsp_hold = '0, last_rsp = '0;
    logic [7:0] last_adr = 8'h00;

    always @(posedge sbclki) begin
        #2;
        if (resetn) begin
            if (sbstbi) begin
                if (!stb_prev) begin
                    if (stb_idx == 0) stb_first = cyc;
                    else check("poll_gap", 32'(gap_len), 32'(POLL_GAP));
                    stb_idx++;
                    stb_len = 0;
                end
                stb_len++;
                last_adr = sbadri;
                check("sbadri", 32'(sbadri), 32'(exp_adr));
                check("sbrwi", 32'(sbrwi), 32'(exp_rwi));
                check("sbdati", 32'(sbdati), 32'(exp_dati));
                check("busy_in_strobe", 32'(busy), 32'd1);
            end else begin
                if (stb_prev) begin
                    if (len_q.size() == 0) fail_now("strobe_unexpected");
                    else check("strobe_len", 32'(stb_len), 32'(len_q.pop_front()));
                    gap_len = 0;
                end
                gap_len++;
            end
            if (rsp_valid) begin
                check("busy_in_rsp", 32'(busy), 32'd1);
                check("cmd_ready_in_rsp", 32'(cmd_ready), 32'd0);
                if (!rsp_prev) begin
                    rsp_first = cyc;
                    rsp_hold  = {rsp_status, rsp_rdata};
                    last_rsp  = rsp_hold;
                    if (exp_q.size() == 0) fail_now("rsp_unexpected");
                    else check("rsp", 32'(rsp_hold), 32'(exp_q.pop_front()));
                end else begin
                    check("rsp_stable", 32'({rsp_status, rsp_rdata}), 32'(rsp_hold));
                end
            end
        end
        stb_prev = resetn ? sbstbi : 1'b0;
        rsp_prev = resetn ? rsp_valid : 1'b0;
    end

    // ---------------- driver ----------------
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] rg, input logic [7:0] wd,
                           input logic [7:0] mk, input int dly, input int hold,
                           input int irq_after);
        logic [1:0] st;
        logic [7:0] rd;
        int         nstb, acc, n;
        st = 2'd0; rd = 8'h00; nstb = 0;
        // response model from the command rules
        if (op == 2'd3) begin
`ifdef SB_I2C_CMD_SEQ_IRQ_WAIT_EN
            st = (irq_after > 0) ? 2'd0 : 2'd1;
`else
            st = 2'd3;
`endif
        end else if (op == 2'd2) begin
            st = 2'd2;
            for (int i = 0; i < POLL_MAX; i++) begin
                nstb++;
                if (dly == 0) begin
                    len_q.push_back(ACK_TIMEOUT); st = 2'd1; rd = 8'h00;
                    break;
                end
                len_q.push_back(dly);
                rd = rd_vals[i];
                if ((rd & mk) == (wd & mk)) begin
                    st = 2'd0;
                    break;
                end
            end
        end else begin
            nstb = 1;
            if (dly == 0) begin
                len_q.push_back(ACK_TIMEOUT); st = 2'd1;
            end else begin
                len_q.push_back(dly);
                rd = (op == 2'd1) ? rd_vals[0] : 8'h00;
            end
        end
        exp_q.push_back({st, rd});
        exp_adr  = {BUS_ADDR74, rg};
        exp_rwi  = (op == 2'd0);
        exp_dati = (op == 2'd0) ? wd : 8'h00;
        ack_dly  = dly;
        rd_q.delete();
        for (int i = 0; i < 4; i++) rd_q.push_back(rd_vals[i]);
        stb_idx = 0; stb_first = -1; rsp_first = -1; ack_edge = -1;

        @(negedge sbclki);
        cmd_valid = 1'b1; cmd_op = op; cmd_reg = rg; cmd_wdata = wd; cmd_mask = mk;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge sbclki);
            n++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_ready_timeout");
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(posedge sbclki);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_reg   = 4'($urandom_range(0, 15));
        cmd_wdata = 8'($urandom_range(0, 255));
        cmd_mask  = 8'($urandom_range(0, 255));

        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge sbclki);
            n++;
            if (irq_after > 0 && n == irq_after) i2cirq = 1'b1;
        end
        if (!rsp_valid) begin
            fail_now("rsp_timeout");
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge sbclki);
            check("rsp_valid_held", 32'(rsp_valid), 32'd1);
            check("cmd_ready_held", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge sbclki);
        #1;
        rsp_ready = 1'b0;
        i2cirq    = 1'b0;
        check("rsp_dropped", 32'(rsp_valid), 32'd0);
        check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
        check("strobe_count", 32'(stb_idx), 32'(nstb));
        if (nstb > 0) check("accept_to_strobe", 32'(stb_first + 1 - acc), 32'd1);
        if (dly != 0 && nstb > 0) check("ack_to_rsp", 32'(rsp_first + 1 - ack_edge), 32'd2);
`ifndef SB_I2C_CMD_SEQ_IRQ_WAIT_EN
        if (op == 2'd3) check("badop_latency", 32'(rsp_first + 1 - acc), 32'd1);
`endif
    endtask

    task automatic reset_mid_strobe();
        int n;
        ack_dly = 0;
        exp_adr = {BUS_ADDR74, 4'h4}; exp_rwi = 1'b0; exp_dati = 8'h00;
        stb_idx = 0;
        @(negedge sbclki);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_reg = 4'h4;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge sbclki);
            n++;
        end
        @(posedge sbclki);
        #1 cmd_valid = 1'b0;
        repeat (10) @(posedge sbclki);
        #3 resetn = 1'b0;
        #1;
        check("rst_sbstbi", 32'(sbstbi), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge sbclki);
        resetn = 1'b1;
        repeat (3) @(negedge sbclki);
        check("post_rst_idle", 32'(rsp_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge sbclki);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sbstbi", 32'(sbstbi), 32'd0);
        check("reset_bus", 32'({sbrwi, sbadri, sbdati}), 32'd0);
        check("reset_rsp", 32'({rsp_status, rsp_rdata}), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(S_IDLE));
        resetn = 1'b1;

        rd_vals = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_cmd(2'd0, 4'h8, 8'hA5, 8'h00, 2, 0, 0);
        check("t1_adr_literal", 32'(last_adr), 32'h38);
        check("t1_len_literal", 32'(stb_len), 32'd2);
        check("t1_rsp_literal", 32'(last_rsp), 32'h000);

        rd_vals = '{8'h5E, 8'h00, 8'h00, 8'h00};
        run_cmd(2'd1, 4'hC, 8'h77, 8'h00, 1, 5, 0);
        check("t2_rsp_literal", 32'(last_rsp), 32'h05E);

        stray_en = 1'b1;
        rd_vals = '{8'h00, 8'h00, 8'h81, 8'h00};
        run_cmd(2'd2, 4'hC, 8'h80, 8'h80, 1, 0, 0);
        stray_en = 1'b0;
        check("t3_strobes_literal", 32'(stb_idx), 32'd3);
        check("t3_rsp_literal", 32'(last_rsp), 32'h081);

        rd_vals = '{8'h00, 8'h01, 8'h7F, 8'hFF};
        run_cmd(2'd2, 4'hC, 8'h80, 8'h80, 3, 0, 0);
        check("t4_rsp_literal", 32'(last_rsp), {22'd0, 2'd2, 8'h7F});

        rd_vals = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_cmd(2'd0, 4'hD, 8'h3C, 8'h00, 0, 0, 0);
        check("t5_len_literal", 32'(stb_len), 32'd64);
        check("t5_rsp_literal", 32'(last_rsp), {22'd0, 2'd1, 8'h00});

        reset_mid_strobe();

        rd_vals = '{8'hC3, 8'h00, 8'h00, 8'h00};
        run_cmd(2'd1, 4'h0, 8'h00, 8'h00, 5, 0, 0);
        run_cmd(2'd0, 4'hF, 8'h5A, 8'h00, 1, 2, 0);
        rd_vals = '{8'hF5, 8'h00, 8'h00, 8'h00};
        run_cmd(2'd2, 4'h9, 8'h05, 8'h0F, 2, 0, 0);
        run_cmd(2'd2, 4'h2, 8'h01, 8'h01, 0, 0, 0);

`ifdef SB_I2C_CMD_SEQ_IRQ_WAIT_EN
        run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 1, 0, 10);
        check("t6_rsp_literal", 32'(last_rsp), 32'h000);
`else
        run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 1, 0, 0);
        check("t6_rsp_literal", 32'(last_rsp), {22'd0, 2'd3, 8'h00});
`endif
        check("t6_no_strobes", 32'(stb_idx), 32'd0);

        repeat (4) @(negedge sbclki);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("len_q_drained", 32'(len_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        fail_now("watchdog");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
